// File: rtl/edge_event_arbiter.sv
// Edge-capture arbiter: detects per-channel rising/falling edges, queues them as pending
// flags and offers them one at a time, round-robin, over a valid/ready handshake.
module edge_event_arbiter #(
  parameter int CH    = 4,
  parameter int IDX_W = 2
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic [CH-1:0]    sig_in,
  input  logic [CH-1:0]    edge_sel,
  input  logic [CH-1:0]    enable,
  output logic             ev_valid,
  input  logic             ev_ready,
  output logic [IDX_W-1:0] ev_ch,
  output logic [CH-1:0]    ovf,
  input  logic             ovf_clr,
  output logic [CH-1:0]    pending
);

  typedef enum logic {IDLE, OFFER} state_t;

  state_t           state, state_n;
  logic [CH-1:0]    delay_q;
  logic [CH-1:0]    strobe, capture, clr_vec, pending_n, ovf_set;
  logic [IDX_W-1:0] last_grant, last_grant_n, ev_ch_n, rr_pick, rr_idx;
  logic             rr_found, handshake;

  assign strobe    = (edge_sel & sig_in & ~delay_q) | (~edge_sel & ~sig_in & delay_q);
  assign capture   = strobe & enable;
  assign ev_valid  = (state == OFFER);
  assign handshake = ev_valid & ev_ready;

  // A fresh edge on the channel being retired re-arms it instead of counting as overflow.
  always_comb begin
    clr_vec = '0;
    if (handshake) clr_vec[ev_ch] = 1'b1;
  end

  assign pending_n = (pending & ~clr_vec) | capture;
  assign ovf_set   = capture & pending & ~clr_vec;

  always_comb begin
    rr_pick  = '0;
    rr_found = 1'b0;
    rr_idx   = '0;
    for (int k = 1; k <= CH; k++) begin
      rr_idx = IDX_W'((int'(last_grant) + k) % CH);
      if (!rr_found && pending[rr_idx]) begin
        rr_found = 1'b1;
        rr_pick  = rr_idx;
      end
    end
  end

  always_comb begin
    state_n      = state;
    ev_ch_n      = ev_ch;
    last_grant_n = last_grant;
    case (state)
      IDLE: begin
        if (rr_found) begin
          state_n = OFFER;
          ev_ch_n = rr_pick;
        end
      end
      OFFER: begin
        if (ev_ready) begin
          state_n      = IDLE;
          last_grant_n = ev_ch;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= IDLE;
      ev_ch      <= '0;
      last_grant <= IDX_W'(CH - 1);
    end else begin
      state      <= state_n;
      ev_ch      <= ev_ch_n;
      last_grant <= last_grant_n;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      delay_q <= '0;
      pending <= '0;
      ovf     <= '0;
    end else begin
      delay_q <= sig_in;
      pending <= pending_n;
      ovf     <= (ovf_clr ? '0 : ovf) | ovf_set;
    end
  end

endmodule

// File: doc/edge_event_arbiter.md
EDGE_EVENT_ARBITER -- requirements
Module: edge_event_arbiter

Interface
REQ-001 Parameter: CH, default 4, number of monitored input channels; legal range 2..8.
REQ-002 Parameter: IDX_W, default 2, channel index width; SHALL equal ceil(log2(CH)).
REQ-003 Port: clk  input  1  single clock; all state on rising edge.
REQ-004 Port: n_rst  input  1  asynchronous, active-low reset.
REQ-005 Port: sig_in  input  CH  monitored signals, synchronous to clk.
REQ-006 Port: edge_sel  input  CH  per-channel edge type; 1 = rising, 0 = falling.
REQ-007 Port: enable  input  CH  per-channel capture enable.
REQ-008 Port: ev_valid  output  1  event offered.
REQ-009 Port: ev_ready  input  1  consumer accepts event.
REQ-010 Port: ev_ch  output  IDX_W  channel index of offered event.
REQ-011 Port: ovf  output  CH  sticky per-channel overflow flags.
REQ-012 Port: ovf_clr  input  1  clears all ovf bits.
REQ-013 Port: pending  output  CH  per-channel captured-but-undelivered flags.

Function
REQ-014 Per channel: delay register SHALL hold the previous-cycle sig_in.
REQ-015 Edge strobe, channel i: edge_sel[i]=1 -> sig_in[i] & ~delay[i]; edge_sel[i]=0 -> ~sig_in[i] & delay[i].
REQ-016 Capture: an edge strobe with enable[i]=1 SHALL set pending[i] at the next clock edge.
REQ-017 Edges with enable[i]=0 SHALL be ignored; existing pending[i] SHALL be kept.
REQ-018 Changing edge_sel or enable SHALL NOT alter delay registers.
REQ-019 FSM states: IDLE and OFFER.
REQ-020 IDLE: if any pending bit is set, select a channel round-robin, starting at last_grant+1 (mod CH), latch it into ev_ch, and go to OFFER. Otherwise stay in IDLE.
REQ-021 OFFER: ev_valid=1; ev_ch SHALL stay stable until handshake.
REQ-022 Handshake = ev_valid & ev_ready. On handshake: clear pending[ev_ch], set last_grant=ev_ch, go to IDLE.
REQ-023 ev_valid SHALL be 0 in IDLE. Maximum throughput is one event per 2 cycles.
REQ-024 Latency: edge visible on sig_in in cycle N -> pending set at clock N+1 -> ev_valid high after clock N+2, provided the FSM is IDLE with no other pending.
REQ-025 Overflow: an enabled edge on channel i while pending[i]=1 and pending[i] is not cleared that cycle SHALL set ovf[i]; pending[i] stays 1.
REQ-026 An enabled edge on ev_ch in its handshake cycle SHALL leave pending[ev_ch]=1 and SHALL NOT set ovf.
REQ-027 ovf_clr=1 SHALL clear all ovf bits next clock. A simultaneous overflow set on channel i wins: ovf[i]=1.
REQ-028 ev_ready while in IDLE SHALL have no effect.
REQ-029 Pending bits of channels not currently offered SHALL be unaffected by the handshake.

Reset
REQ-030 n_rst=0 SHALL immediately force: delay=0, pending=0, ovf=0, ev_valid=0, ev_ch=0, last_grant=CH-1, FSM=IDLE.
REQ-031 Reset mid-OFFER SHALL drop the offered event without a handshake.
REQ-032 With sig_in=1 at reset release and edge_sel=1, a rising edge SHALL be detected in the first cycle after release, because delay resets to 0.
REQ-033 Reset deassertion is synchronised externally; no internal synchroniser.

Verification
REQ-034 Single edge: ch2 rising with enable=4'b0100 and ev_ready=1 -> ev_valid one cycle, ev_ch=2, pending[2] back to 0 after handshake.
REQ-035 Round-robin: edges on ch0, ch1 and ch3 in the same cycle with ev_ready=1 -> ev_ch order 0,1,3. Then a new ch0 and ch3 edge together -> 0 first, since last_grant=3.
REQ-036 Backpressure/overflow: ch1 falling edge, ev_ready=0 for 10 cycles, second ch1 falling edge -> ev_valid held, ev_ch=1 stable, ovf[1]=1; ovf_clr then -> ovf=0.
REQ-037 Coincident edge and handshake: new ch0 edge in the ch0 handshake cycle -> ovf[0]=0 and a second ch0 event is offered.
REQ-038 Disabled channel: ch3 edge with enable[3]=0 -> no pending[3], no event.
REQ-039 Reset mid-OFFER: assert n_rst while ev_valid=1 -> ev_valid=0 and pending=0 immediately. After release with sig_in[0]=1 and edge_sel[0]=1 -> ch0 event captured.
